// File: rtl/integer_issue_queue.sv
// ============================================================================
// Module   : integer_issue_queue
// Brief    : In-order issue queue buffering integer-class instructions from
//            Dispatch and handing them to the integer ALU over a valid/ready
//            handshake. Full back-pressures Dispatch through stall_out; kill
//            flushes every entry on the next clock edge.
// Options  : INTQ_BYPASS_EN - when defined, an instruction arriving at an
//            empty queue while the ALU is ready is issued in the same cycle
//            without being written into storage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Reservation-station selector codes shared with Dispatch.
`ifndef RS_INTEGER
`define RS_INTEGER 3'd1
`endif
`ifndef RS_LOAD_STORE
`define RS_LOAD_STORE 3'd2
`endif
`ifndef RS_BRANCH
`define RS_BRANCH 3'd3
`endif

module integer_issue_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             kill,
  input  logic             in_valid,
  input  logic [2:0]       rs_destination,
  input  logic [72:0]      rs_integer,
  input  logic [31:0]      dispatched_pc,
  output logic             stall_out,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [3:0]       issue_aluop,
  output logic [4:0]       issue_rd,
  output logic [31:0]      issue_op1,
  output logic [31:0]      issue_op2,
  output logic [31:0]      issue_pc,
  output logic [CNT_W-1:0] occupancy
);

  // One entry is the 73-bit dispatch payload followed by the 32-bit PC.
  localparam int ENTRY_W = 105;

  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];

  logic               full;
  logic               empty;
  logic               class_ok;
  logic               enq;
  logic               bypass;
  logic               wr_en;
  logic               stored_valid;
  logic               deq;
  logic [ENTRY_W-1:0] entry_in;
  logic [ENTRY_W-1:0] issue_entry;

  // Full and empty are told apart by the counter only; pointers alias when
  // the queue is completely full.
  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign class_ok     = (rs_destination == `RS_INTEGER);
  assign entry_in     = {rs_integer, dispatched_pc};
  assign stored_valid = !empty;

  // A full queue refuses input even when the head leaves this cycle, so
  // stall_out never depends on issue_ready.
  assign enq = in_valid && class_ok && !full && !kill;

`ifdef INTQ_BYPASS_EN
  // Empty queue plus a ready ALU: hand the instruction straight through.
  assign bypass = empty && enq && issue_ready;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed instruction never occupies an entry.
  assign wr_en = enq && !bypass;

  // Only stored entries are dequeued; a handshake during kill is void.
  assign deq = stored_valid && issue_ready && !kill;

  assign stall_out = full;
  assign occupancy = count_q;

  // Next-state for pointers and occupancy, with kill taking priority.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (kill) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) begin
        tail_d = tail_q + PTR_W'(1);
      end
      if (deq) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(deq);
    end
  end

  // Control state flops; asynchronous reset empties the queue at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage next-state: write the incoming entry at the tail slot.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[tail_q] = entry_in;
    end
  end

  // Storage flops carry no reset; contents are meaningless while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Issue selection: head entry when occupied, otherwise the bypassed
  // input (if enabled), otherwise all zeros.
  always_comb begin
    issue_valid = 1'b0;
    issue_entry = '0;
    if (stored_valid) begin
      issue_valid = 1'b1;
      issue_entry = mem_q[head_q];
    end else if (bypass) begin
      issue_valid = 1'b1;
      issue_entry = entry_in;
    end
  end

  // Field split of the selected entry: {aluop, rd, op1, op2, pc}.
  assign issue_aluop = issue_entry[104:101];
  assign issue_rd    = issue_entry[100:96];
  assign issue_op1   = issue_entry[95:64];
  assign issue_op2   = issue_entry[63:32];
  assign issue_pc    = issue_entry[31:0];

endmodule

`default_nettype wire

// File: tb/tb_integer_issue_queue.sv
// ============================================================================
// Module   : tb_integer_issue_queue
// Brief    : Directed self-checking bench for integer_issue_queue (DEPTH=4).
//            Expectations follow INTQ_BYPASS_EN when that macro is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef RS_INTEGER
`define RS_INTEGER 3'd1
`endif
`ifndef RS_LOAD_STORE
`define RS_LOAD_STORE 3'd2
`endif
`ifndef RS_BRANCH
`define RS_BRANCH 3'd3
`endif

module tb_integer_issue_queue;

  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             kill;
  logic             in_valid;
  logic [2:0]       rs_destination;
  logic [72:0]      rs_integer;
  logic [31:0]      dispatched_pc;
  logic             stall_out;
  logic             issue_valid;
  logic             issue_ready;
  logic [3:0]       issue_aluop;
  logic [4:0]       issue_rd;
  logic [31:0]      issue_op1;
  logic [31:0]      issue_op2;
  logic [31:0]      issue_pc;
  logic [CNT_W-1:0] occupancy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  integer_issue_queue #(.DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .kill           (kill),
    .in_valid       (in_valid),
    .rs_destination (rs_destination),
    .rs_integer     (rs_integer),
    .dispatched_pc  (dispatched_pc),
    .stall_out      (stall_out),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_aluop    (issue_aluop),
    .issue_rd       (issue_rd),
    .issue_op1      (issue_op1),
    .issue_op2      (issue_op2),
    .issue_pc       (issue_pc),
    .occupancy      (occupancy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Instruction fields are a fixed function of rd so any issued op can be
  // recognised: aluop=rd[3:0], op1=0x10+rd-1, op2=0x100*rd, pc=0x1000+4*rd.
  function automatic logic [31:0] op1_of(input int rd);
    return 32'(32'h10 + rd - 1);
  endfunction
  function automatic logic [31:0] op2_of(input int rd);
    return 32'(32'h100 * rd);
  endfunction
  function automatic logic [31:0] pc_of(input int rd);
    return 32'(32'h1000 + 4 * rd);
  endfunction

  task automatic drive_op(input int rd, input logic [2:0] dst);
    in_valid       = 1'b1;
    rs_destination = dst;
    rs_integer     = {4'(rd), 5'(rd), op1_of(rd), op2_of(rd)};
    dispatched_pc  = pc_of(rd);
  endtask

  task automatic drive_idle;
    in_valid       = 1'b0;
    rs_destination = `RS_INTEGER;
    rs_integer     = '0;
    dispatched_pc  = '0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input int rd);
    chk({tag, "/valid"}, 64'(issue_valid), 64'd1);
    chk({tag, "/rd"},    64'(issue_rd),    64'(rd));
    chk({tag, "/aluop"}, 64'(issue_aluop), 64'(rd % 16));
    chk({tag, "/op1"},   64'(issue_op1),   64'(op1_of(rd)));
    chk({tag, "/op2"},   64'(issue_op2),   64'(op2_of(rd)));
    chk({tag, "/pc"},    64'(issue_pc),    64'(pc_of(rd)));
  endtask

  task automatic check_empty(input string tag);
    chk({tag, "/valid"}, 64'(issue_valid), 64'd0);
    chk({tag, "/occ"},   64'(occupancy),   64'd0);
    chk({tag, "/rd"},    64'(issue_rd),    64'd0);
    chk({tag, "/pc"},    64'(issue_pc),    64'd0);
    chk({tag, "/stall"}, 64'(stall_out),   64'd0);
  endtask

  initial begin
    reset       = 1'b1;
    kill        = 1'b0;
    issue_ready = 1'b0;
    drive_idle();
    tick();
    tick();
    check_empty("reset");
    reset = 1'b0;
    tick();
    check_empty("idle");

    // Fill to DEPTH with the ALU stalled; the fifth op is held off.
    for (int i = 1; i <= 4; i++) begin
      drive_op(i, `RS_INTEGER);
      #1;
      chk($sformatf("fill%0d/stall", i), 64'(stall_out), 64'd0);
      tick();
    end
    drive_op(5, `RS_INTEGER);
    #1;
    chk("full/occ", 64'(occupancy), 64'd4);
    chk("full/stall", 64'(stall_out), 64'd1);
    check_head("full/head", 1);
    tick();
    chk("held/occ", 64'(occupancy), 64'd4);
    check_head("held/head", 1);

    // Full with ready and input together: dequeue only, input refused.
    issue_ready = 1'b1;
    #1;
    chk("fulldeq/stall", 64'(stall_out), 64'd1);
    check_head("issue1", 1);
    tick();
    chk("fulldeq/occ", 64'(occupancy), 64'd3);
    chk("fulldeq/stall_after", 64'(stall_out), 64'd0);
    check_head("issue2", 2);
    tick();
    drive_idle();
    #1;
    chk("swap/occ", 64'(occupancy), 64'd3);
    check_head("issue3", 3);
    tick();
    check_head("issue4", 4);
    tick();
    check_head("issue5", 5);
    tick();
    check_empty("drained");

    // Other reservation-station classes are ignored.
    issue_ready = 1'b0;
    drive_op(7, `RS_INTEGER);
    tick();
    drive_op(12, `RS_LOAD_STORE);
    #1;
    chk("ls/stall", 64'(stall_out), 64'd0);
    tick();
    chk("ls/occ", 64'(occupancy), 64'd1);
    drive_op(13, `RS_BRANCH);
    tick();
    chk("br/occ", 64'(occupancy), 64'd1);
    drive_op(8, `RS_INTEGER);
    tick();
    drive_idle();
    #1;
    chk("cls/occ", 64'(occupancy), 64'd2);
    issue_ready = 1'b1;
    check_head("cls/first", 7);
    tick();
    check_head("cls/second", 8);
    tick();
    check_empty("cls/drained");

    // Ten back-to-back ops with the ALU always ready: pointers wrap.
    for (int k = 0; k <= 10; k++) begin
      if (k < 10) drive_op(10 + k, `RS_INTEGER);
      else        drive_idle();
      #1;
`ifdef INTQ_BYPASS_EN
      if (k < 10) check_head($sformatf("b2b%0d", k), 10 + k);
      else        chk("b2b10/valid", 64'(issue_valid), 64'd0);
      chk($sformatf("b2b%0d/occ", k), 64'(occupancy), 64'd0);
`else
      if (k >= 1) check_head($sformatf("b2b%0d", k), 10 + k - 1);
      else        chk("b2b0/valid", 64'(issue_valid), 64'd0);
      chk($sformatf("b2b%0d/occ", k), 64'(occupancy), (k >= 1) ? 64'd1 : 64'd0);
`endif
      tick();
    end
    drive_idle();
    #1;
    check_empty("b2b/drained");

    // Kill with three queued and a new op arriving: everything is dropped.
    issue_ready = 1'b0;
    for (int i = 20; i <= 22; i++) begin
      drive_op(i, `RS_INTEGER);
      tick();
    end
    drive_op(23, `RS_INTEGER);
    kill        = 1'b1;
    issue_ready = 1'b1;
    #1;
    chk("kill/occ_before", 64'(occupancy), 64'd3);
    check_head("kill/head", 20);
    tick();
    kill        = 1'b0;
    issue_ready = 1'b0;
    drive_idle();
    #1;
    check_empty("kill/after");
    tick();
    check_empty("kill/after2");
    drive_op(24, `RS_INTEGER);
    tick();
    drive_idle();
    #1;
    chk("kill/reuse_occ", 64'(occupancy), 64'd1);
    check_head("kill/reuse", 24);
    issue_ready = 1'b1;
    tick();
    check_empty("kill/reuse_drained");

    // Asynchronous reset with three queued clears state without a clock.
    issue_ready = 1'b0;
    for (int i = 25; i <= 27; i++) begin
      drive_op(i, `RS_INTEGER);
      tick();
    end
    drive_idle();
    #1;
    chk("rst/occ_before", 64'(occupancy), 64'd3);
    reset = 1'b1;
    #1;
    check_empty("rst/async");
    #1;
    reset = 1'b0;
    tick();
    check_empty("rst/after");

`ifdef INTQ_BYPASS_EN
    // Same-cycle bypass into an empty queue, then the not-ready fallback.
    issue_ready = 1'b1;
    drive_op(30, `RS_INTEGER);
    #1;
    check_head("byp", 30);
    chk("byp/occ", 64'(occupancy), 64'd0);
    tick();
    drive_idle();
    #1;
    check_empty("byp/after");
    issue_ready = 1'b0;
    drive_op(31, `RS_INTEGER);
    #1;
    chk("bypnr/valid", 64'(issue_valid), 64'd0);
    tick();
    drive_idle();
    #1;
    chk("bypnr/occ", 64'(occupancy), 64'd1);
    check_head("bypnr/head", 31);
    issue_ready = 1'b1;
    tick();
    check_empty("bypnr/drained");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
